nearest_centroid: RTL and testbench
===================================

Name: nearest_centroid

Overview:
- K-means assignment stage directly downstream of the `distance` squared-distance pipeline.
- Holds up to K centroid coordinates in a register file and accepts one 8-bit (x,y) point per transaction. It streams every active centroid through one internal `distance` instance, tracks the running minimum, and returns the index and halved squared distance of the nearest centroid.
- Output feeds the centroid-accumulator/update stage.

Parameters:
- K, 4, maximum number of centroids held (2..16).
- IDX_W, 2, centroid index width; must equal ceil(log2(K)).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- cent_we  in  1  centroid write strobe
- cent_addr  in  IDX_W  centroid write index
- cent_x  in  8  centroid x coordinate
- cent_y  in  8  centroid y coordinate
- n_cent  in  IDX_W+1  number of active centroids, sampled on point accept
- s_valid  in  1  input point valid
- s_ready  out  1  block ready to accept a point
- s_x  in  8  point x
- s_y  in  8  point y
- m_valid  out  1  result valid
- m_ready  in  1  downstream accepts result
- m_idx  out  IDX_W  index of nearest centroid
- m_dist  out  16  (dx²+dy²)>>1 to nearest centroid
- busy  out  1  high in any state other than IDLE

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk. `rst` also drives the internal `distance` instance.
- Reset values:
  - s_ready=1 (IDLE), m_valid=0, m_idx=0, m_dist=0, busy=0.
  - All centroid registers = (0,0).
  - Tag pipeline cleared; FSM = IDLE.
- Distance unit: 3-cycle latency; result = floor((dx²+dy²)/2), range 0..65025. Inputs are presented on the cycle a centroid is issued.
- FSM states:
  - IDLE: s_ready=1. On s_valid&&s_ready, latch s_x/s_y, latch n_eff = clamp(n_cent,1,K) (0 is treated as 1, values above K as K), clear the issue counter, set min_dist=16'hFFFF and min_idx=0, go to ISSUE.
  - ISSUE: each cycle, drive centroid[cnt] and the latched point into `distance`. Push {valid=1, idx=cnt} into a 3-deep tag shift register. Increment cnt. After issuing cnt=n_eff-1, go to DRAIN.
  - DRAIN: push valid=0 tags. When the tag for the last centroid has emerged and been compared, go to OUT.
  - OUT: m_valid=1. m_idx and m_dist are held stable until m_ready=1. On m_valid&&m_ready go to IDLE.
- Compare: on every cycle the tag-pipe output is valid, if sq_distance < min_dist (strict), update min_dist/min_idx. Ties therefore keep the lower index.
- The first valid result always updates the minimum, even 16'hFFFF versus the max of 65025.
- Latency: accept edge at cycle 0; centroids issued in cycles 1..n_eff; last result visible cycle n_eff+3; m_valid asserted cycle n_eff+4. For K=4, n_eff=4 this is 8 cycles.
- Throughput: s_ready is high only in IDLE, giving at most one point per n_eff+5 cycles with m_ready held high.
- Centroid writes:
  - Accepted only when busy=0. cent_we during busy=1 is ignored and the register is unchanged.
  - A write and a point accept in the same IDLE cycle both take effect. The write lands on the edge, so the new value is used from issue cycle 1.
  - cent_addr ≥ K is ignored.
- n_cent, s_x/s_y changes after accept have no effect on the transaction in flight.
- Reset mid-operation: the FSM returns to IDLE next edge, the in-flight point is dropped, the tag pipe is cleared, m_valid drops to 0, and centroids return to (0,0).
- No combinational path from m_ready to s_ready or from s_valid to m_valid.

Test Plan:
- Basic assignment: centroids (0,0),(100,100),(200,50),(255,255); n_cent=4; point (190,60); m_ready=1 → m_valid exactly 8 cycles after accept, m_idx=2, m_dist=100. The internal minimum sequence is 19850, 4850, 100; 21125 does not update.
- Tie and rounding: c0=c1=(10,10), n_cent=2, point (12,10) → m_idx=0, m_dist=2. Then point (11,10) → m_dist=0 (floor of 1/2).
- Extremes and active count:
  - c0=(255,255), c1..c3=(0,0), n_cent=1, point (0,0) → m_idx=0, m_dist=65025. The closer inactive centroids are ignored.
  - n_cent=0 behaves identically to n_cent=1.
- Backpressure: hold m_ready=0 for 5 cycles after m_valid → m_idx/m_dist stable, s_ready=0, and a s_valid pulse is not accepted. Raise m_ready → one handshake, s_ready=1 on the next cycle.
- Write during busy: after accept, pulse cent_we to addr 2 with (190,60) → result unchanged from the basic case. The same write in IDLE followed by point (190,60) → m_idx=2, m_dist=0.
- Reset mid-op: assert rst for 1 cycle in DRAIN → m_valid never rises for that point, all outputs return to reset values, and centroids read back as (0,0). With n_cent=4 and no writes, a subsequent point (3,4) gives m_idx=0, m_dist=12.

Source files
------------

// File: rtl/nearest_centroid_if.sv
// Point-in / result-out handshake bundle for nearest_centroid.
//   s_valid/s_ready/s_x/s_y      : one 8-bit (x,y) point per transaction
//   m_valid/m_ready/m_idx/m_dist : nearest centroid index and halved squared distance
// master: the side that supplies points and consumes results.
// slave : the nearest_centroid block.
interface nearest_centroid_if #(
  parameter int IDX_W = 2
);
  logic             s_valid;
  logic             s_ready;
  logic [7:0]       s_x;
  logic [7:0]       s_y;
  logic             m_valid;
  logic             m_ready;
  logic [IDX_W-1:0] m_idx;
  logic [15:0]      m_dist;

  modport master (
    output s_valid, s_x, s_y, m_ready,
    input  s_ready, m_valid, m_idx, m_dist
  );

  modport slave (
    input  s_valid, s_x, s_y, m_ready,
    output s_ready, m_valid, m_idx, m_dist
  );
endinterface

// File: rtl/nearest_centroid.sv
// K-means assignment stage.
// distance: 3-cycle pipelined squared-distance unit, result floor((dx^2+dy^2)/2).
//   clk, rst            : clock, synchronous active-high reset
//   ax, ay, bx, by      : the two 8-bit points, presented on the issue cycle
//   sq_distance         : halved squared distance, valid 3 cycles after issue
// nearest_centroid: holds up to K centroids, streams the active ones through
// one distance unit per point and returns the nearest one.
//   clk, rst            : clock, synchronous active-high reset
//   cent_we/addr/x/y    : centroid register write port (ignored while busy)
//   n_cent              : active centroid count, sampled on point accept
//   busy                : high whenever a point is in flight or a result is pending
//   bus (slave)         : point input stream and result output stream

module distance (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ax,
  input  logic [7:0]  ay,
  input  logic [7:0]  bx,
  input  logic [7:0]  by,
  output logic [15:0] sq_distance
);
  logic [7:0]  dx, dy;
  logic [15:0] sqx, sqy;
  logic [16:0] sum;

  assign sum = {1'b0, sqx} + {1'b0, sqy};

  always_ff @(posedge clk) begin
    if (rst) begin
      dx          <= '0;
      dy          <= '0;
      sqx         <= '0;
      sqy         <= '0;
      sq_distance <= '0;
    end else begin
      dx          <= (ax >= bx) ? (ax - bx) : (bx - ax);
      dy          <= (ay >= by) ? (ay - by) : (by - ay);
      sqx         <= 16'(dx) * 16'(dx);
      sqy         <= 16'(dy) * 16'(dy);
      sq_distance <= sum[16:1];
    end
  end
endmodule

module nearest_centroid #(
  parameter int K     = 4,
  parameter int IDX_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cent_we,
  input  logic [IDX_W-1:0]  cent_addr,
  input  logic [7:0]        cent_x,
  input  logic [7:0]        cent_y,
  input  logic [IDX_W:0]    n_cent,
  output logic              busy,
  nearest_centroid_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

  state_t state, state_next;

  // centroid register file
  logic [7:0] cx [K];
  logic [7:0] cy [K];

  // latched transaction
  logic [7:0]       px, py;
  logic [IDX_W:0]   n_eff;
  logic [IDX_W-1:0] cnt;

  // running minimum and published result
  logic [15:0]      min_dist;
  logic [IDX_W-1:0] min_idx;
  logic [15:0]      res_dist;
  logic [IDX_W-1:0] res_idx;

  // tag pipe, aligned with the distance unit latency
  logic [2:0]       tag_v;
  logic [IDX_W-1:0] tag_idx [3];

  logic [15:0]      sq_distance;
  logic [IDX_W:0]   n_clamp;
  logic [IDX_W:0]   last_idx;
  logic             accept, last_issue, last_tag, better, wr_ok;
  logic [15:0]      cand_dist;
  logic [IDX_W-1:0] cand_idx;

  distance u_distance (
    .clk         (clk),
    .rst         (rst),
    .ax          (cx[cnt]),
    .ay          (cy[cnt]),
    .bx          (px),
    .by          (py),
    .sq_distance (sq_distance)
  );

  always_comb begin
    n_clamp = n_cent;
    if (n_cent == '0)
      n_clamp = (IDX_W+1)'(1);
    else if (n_cent > (IDX_W+1)'(K))
      n_clamp = (IDX_W+1)'(K);
  end

  assign last_idx   = n_eff - (IDX_W+1)'(1);
  assign accept     = (state == IDLE) && bus.s_valid;
  assign last_issue = ({1'b0, cnt} == last_idx);
  assign last_tag   = tag_v[2] && ({1'b0, tag_idx[2]} == last_idx);
  assign wr_ok      = (state == IDLE) && cent_we && ({1'b0, cent_addr} < (IDX_W+1)'(K));

  // Strict compare keeps the lower index on ties; the min_dist seed of
  // 16'hFFFF exceeds the largest possible distance, so the first valid
  // result always wins.
  assign better    = tag_v[2] && (sq_distance < min_dist);
  assign cand_dist = better ? sq_distance : min_dist;
  assign cand_idx  = better ? tag_idx[2] : min_idx;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    bus.s_ready = 1'b0;
    bus.m_valid = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        bus.s_ready = 1'b1;
        busy        = 1'b0;
        if (bus.s_valid) state_next = ISSUE;
      end
      ISSUE: begin
        if (last_issue) state_next = DRAIN;
      end
      DRAIN: begin
        if (last_tag) state_next = OUT;
      end
      OUT: begin
        bus.m_valid = 1'b1;
        if (bus.m_ready) state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < K; i++) begin
        cx[i] <= '0;
        cy[i] <= '0;
      end
      px         <= '0;
      py         <= '0;
      n_eff      <= (IDX_W+1)'(1);
      cnt        <= '0;
      min_dist   <= '1;
      min_idx    <= '0;
      res_dist   <= '0;
      res_idx    <= '0;
      tag_v      <= '0;
      tag_idx[0] <= '0;
      tag_idx[1] <= '0;
      tag_idx[2] <= '0;
    end else begin
      if (wr_ok) begin
        cx[cent_addr] <= cent_x;
        cy[cent_addr] <= cent_y;
      end

      tag_v      <= {tag_v[1:0], (state == ISSUE)};
      tag_idx[0] <= cnt;
      tag_idx[1] <= tag_idx[0];
      tag_idx[2] <= tag_idx[1];

      if (better) begin
        min_dist <= sq_distance;
        min_idx  <= tag_idx[2];
      end

      case (state)
        IDLE: begin
          if (accept) begin
            px       <= bus.s_x;
            py       <= bus.s_y;
            n_eff    <= n_clamp;
            cnt      <= '0;
            min_dist <= '1;
            min_idx  <= '0;
          end
        end
        ISSUE: cnt <= cnt + IDX_W'(1);
        DRAIN: begin
          // publish including the final compare happening on this same edge
          if (last_tag) begin
            res_dist <= cand_dist;
            res_idx  <= cand_idx;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.m_idx  = res_idx;
  assign bus.m_dist = res_dist;
endmodule

// File: tb/tb_nearest_centroid.sv
// Self-checking bench for nearest_centroid: directed vector table, hand-written
// backpressure / write-while-busy / reset-mid-operation sequences, and random
// points checked against a plain arithmetic nearest-centroid model.
module tb_nearest_centroid;
  logic       clk = 1'b0;
  logic       rst;
  logic       cent_we;
  logic [1:0] cent_addr;
  logic [7:0] cent_x, cent_y;
  logic [2:0] n_cent;
  logic       busy;

  nearest_centroid_if #(.IDX_W(2)) bus ();

  nearest_centroid #(.K(4), .IDX_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .cent_we   (cent_we),
    .cent_addr (cent_addr),
    .cent_x    (cent_x),
    .cent_y    (cent_y),
    .n_cent    (n_cent),
    .busy      (busy),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model of the centroid register file
  int mcx [4];
  int mcy [4];

  typedef struct {
    int c [8];      // c0x,c0y,c1x,c1y,c2x,c2y,c3x,c3y
    int px, py, n;
    int eidx, edist;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic ref_nearest(input int px, input int py, input int n,
                             output int ridx, output int rdist);
    int ne, d;
    ne = (n < 1) ? 1 : ((n > 4) ? 4 : n);
    ridx = -1;
    rdist = 0;
    for (int i = 0; i < ne; i++) begin
      d = ((px - mcx[i]) * (px - mcx[i]) + (py - mcy[i]) * (py - mcy[i])) / 2;
      if (ridx < 0 || d < rdist) begin
        ridx = i;
        rdist = d;
      end
    end
  endtask

  task automatic write_cent(input int a, input int x, input int y);
    @(negedge clk);
    cent_we = 1'b1;
    cent_addr = 2'(a);
    cent_x = 8'(x);
    cent_y = 8'(y);
    @(negedge clk);
    cent_we = 1'b0;
    mcx[a] = x;
    mcy[a] = y;
  endtask

  // Runs one point. Starts and ends at a negedge with the DUT idle.
  // idle_wr: centroid write in the accept cycle; busy_wr: write in issue cycle 1.
  // bp: cycles m_ready is held low once m_valid is up.
  task automatic run_point(input string tag, input int px, input int py, input int n,
                           input bit idle_wr, input bit busy_wr,
                           input int wa, input int wx, input int wy, input int bp,
                           output int ridx, output int rdist);
    int ne, lat, eidx, edist;
    ne = (n < 1) ? 1 : ((n > 4) ? 4 : n);
    ridx = -1;
    rdist = -1;
    check({tag, " s_ready before accept"}, int'(bus.s_ready), 1);
    bus.s_valid = 1'b1;
    bus.s_x = 8'(px);
    bus.s_y = 8'(py);
    n_cent = 3'(n);
    bus.m_ready = (bp == 0);
    if (idle_wr) begin
      cent_we = 1'b1;
      cent_addr = 2'(wa);
      cent_x = 8'(wx);
      cent_y = 8'(wy);
      mcx[wa] = wx;
      mcy[wa] = wy;
    end
    ref_nearest(px, py, n, eidx, edist);
    @(negedge clk);
    // issue cycle 1: scramble inputs that must no longer matter
    bus.s_valid = 1'b0;
    cent_we = 1'b0;
    bus.s_x = 8'($urandom);
    bus.s_y = 8'($urandom);
    n_cent = 3'($urandom);
    if (busy_wr) begin
      cent_we = 1'b1;
      cent_addr = 2'(wa);
      cent_x = 8'(wx);
      cent_y = 8'(wy);
    end
    check({tag, " busy in flight"}, int'(busy), 1);
    check({tag, " s_ready in flight"}, int'(bus.s_ready), 0);
    lat = 1;
    while (!bus.m_valid && lat < 40) begin
      @(negedge clk);
      cent_we = 1'b0;
      lat++;
    end
    check({tag, " latency"}, lat, ne + 4);
    if (!bus.m_valid) begin
      cent_we = 1'b0;
      bus.m_ready = 1'b1;
      return;
    end
    ridx = int'(bus.m_idx);
    rdist = int'(bus.m_dist);
    check({tag, " m_idx vs model"}, ridx, eidx);
    check({tag, " m_dist vs model"}, rdist, edist);
    for (int i = 0; i < bp; i++) begin
      bus.s_valid = (i == 1);
      @(negedge clk);
      check({tag, " hold m_valid"}, int'(bus.m_valid), 1);
      check({tag, " hold m_idx"}, int'(bus.m_idx), eidx);
      check({tag, " hold m_dist"}, int'(bus.m_dist), edist);
      check({tag, " hold s_ready"}, int'(bus.s_ready), 0);
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    @(negedge clk);
    check({tag, " m_valid after handshake"}, int'(bus.m_valid), 0);
    check({tag, " s_ready after handshake"}, int'(bus.s_ready), 1);
    check({tag, " busy after handshake"}, int'(busy), 0);
  endtask

  task automatic set_vec(input int i, input int c0x, input int c0y, input int c1x, input int c1y,
                         input int c2x, input int c2y, input int c3x, input int c3y,
                         input int px, input int py, input int n, input int eidx, input int edist);
    vecs[i].c[0] = c0x; vecs[i].c[1] = c0y; vecs[i].c[2] = c1x; vecs[i].c[3] = c1y;
    vecs[i].c[4] = c2x; vecs[i].c[5] = c2y; vecs[i].c[6] = c3x; vecs[i].c[7] = c3y;
    vecs[i].px = px; vecs[i].py = py; vecs[i].n = n;
    vecs[i].eidx = eidx; vecs[i].edist = edist;
  endtask

  initial begin
    int ri, rd;
    set_vec(0,   0,   0, 100, 100, 200,  50, 255, 255, 190,  60, 4, 2,   100);
    set_vec(1,  10,  10,  10,  10,   0,   0,   0,   0,  12,  10, 2, 0,     2);
    set_vec(2,  10,  10,  10,  10,   0,   0,   0,   0,  11,  10, 2, 0,     0);
    set_vec(3, 255, 255,   0,   0,   0,   0,   0,   0,   0,   0, 1, 0, 65025);
    set_vec(4, 255, 255,   0,   0,   0,   0,   0,   0,   0,   0, 0, 0, 65025);
    set_vec(5,  50,  50,  60,  60,  70,  70,   5,   5,   0,   0, 7, 3,    25);
    set_vec(6,  50,  50,  60,  60,  70,  70,   5,   5,   0,   0, 3, 0,  2500);
    set_vec(7,  20,   0,   0,  20,  10,  10,   0,  20,   0,   0, 4, 2,   100);

    for (int i = 0; i < 4; i++) begin
      mcx[i] = 0;
      mcy[i] = 0;
    end
    rst = 1'b1;
    cent_we = 1'b0;
    cent_addr = '0;
    cent_x = '0;
    cent_y = '0;
    n_cent = 3'd4;
    bus.s_valid = 1'b0;
    bus.s_x = '0;
    bus.s_y = '0;
    bus.m_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("reset s_ready", int'(bus.s_ready), 1);
    check("reset m_valid", int'(bus.m_valid), 0);
    check("reset busy", int'(busy), 0);
    check("reset m_idx", int'(bus.m_idx), 0);
    check("reset m_dist", int'(bus.m_dist), 0);

    // directed vector table
    for (int v = 0; v < 8; v++) begin
      for (int c = 0; c < 4; c++) write_cent(c, vecs[v].c[2*c], vecs[v].c[2*c+1]);
      run_point($sformatf("vec%0d", v), vecs[v].px, vecs[v].py, vecs[v].n,
                1'b0, 1'b0, 0, 0, 0, 0, ri, rd);
      check($sformatf("vec%0d m_idx", v), ri, vecs[v].eidx);
      check($sformatf("vec%0d m_dist", v), rd, vecs[v].edist);
    end

    // basic centroids again, held result under backpressure
    write_cent(0, 0, 0);
    write_cent(1, 100, 100);
    write_cent(2, 200, 50);
    write_cent(3, 255, 255);
    run_point("backpressure", 190, 60, 4, 1'b0, 1'b0, 0, 0, 0, 5, ri, rd);
    check("backpressure m_idx", ri, 2);
    check("backpressure m_dist", rd, 100);

    // write while busy is dropped
    run_point("busy write", 190, 60, 4, 1'b0, 1'b1, 2, 190, 60, 0, ri, rd);
    check("busy write m_idx", ri, 2);
    check("busy write m_dist", rd, 100);

    // write in the accept cycle is seen by the same point
    run_point("idle write", 190, 60, 4, 1'b1, 1'b0, 2, 190, 60, 0, ri, rd);
    check("idle write m_idx", ri, 2);
    check("idle write m_dist", rd, 0);

    // reset during DRAIN
    bus.s_valid = 1'b1;
    bus.s_x = 8'd190;
    bus.s_y = 8'd60;
    n_cent = 3'd4;
    @(negedge clk);
    bus.s_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mcx[i] = 0;
      mcy[i] = 0;
    end
    check("midreset m_valid", int'(bus.m_valid), 0);
    check("midreset s_ready", int'(bus.s_ready), 1);
    check("midreset busy", int'(busy), 0);
    check("midreset m_idx", int'(bus.m_idx), 0);
    check("midreset m_dist", int'(bus.m_dist), 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("midreset no m_valid", int'(bus.m_valid), 0);
    end
    run_point("after reset", 3, 4, 4, 1'b0, 1'b0, 0, 0, 0, 0, ri, rd);
    check("after reset m_idx", ri, 0);
    check("after reset m_dist", rd, 12);

    // random points against the model
    for (int it = 0; it < 40; it++) begin
      int nw;
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++)
        write_cent($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255));
      if ($urandom_range(0, 4) == 0) write_cent(1, mcx[0], mcy[0]);
      run_point($sformatf("rand%0d", it), $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 7), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 3), ri, rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
